// File: rtl/csa_accum_sequencer_pkg.sv
// Shared constants, FSM state encoding and helpers for the carry-save accumulator.
package csa_accum_sequencer_pkg;

  localparam int DEF_WIDTH = 64;
  localparam int DEF_CHUNK = 16;
  localparam int DEF_CNT_W = 16;
  localparam int CHUNKS    = DEF_WIDTH / DEF_CHUNK;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCUM   = 2'd1,
    RESOLVE = 2'd2,
    DONE    = 2'd3
  } state_t;

  // Increment v, clamping at the all-ones value of a w-bit counter (w <= 31).
  function automatic logic [31:0] sat_inc(input logic [31:0] v, input int w);
    logic [31:0] max_v;
    max_v = (32'd1 << w) - 32'd1;
    return (v >= max_v) ? max_v : v + 32'd1;
  endfunction

endpackage

// File: rtl/csa_accum_sequencer_csa_3to2_row.sv
// Combinational WIDTH-bit 3:2 carry-save compressor; the carry vector is
// pre-shifted left by one and the majority out of the MSB is dropped.
module csa_3to2_row #(
  parameter int WIDTH = 64
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] c,
  output logic [WIDTH-1:0] sum,
  output logic [WIDTH-1:0] carry
);

  assign carry[0] = 1'b0;

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_sum
    assign sum[gi] = a[gi] ^ b[gi] ^ c[gi];
  end

  for (genvar gi = 0; gi < WIDTH - 1; gi++) begin : g_carry
    assign carry[gi+1] = (a[gi] & b[gi]) | (a[gi] & c[gi]) | (b[gi] & c[gi]);
  end

endmodule

// File: rtl/csa_accum_sequencer.sv
// Streaming multi-operand accumulator: carry-save accumulation per beat, then a
// chunked ripple resolve of the redundant pair before presenting the result.
module csa_accum_sequencer
  import csa_accum_sequencer_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CHUNK = DEF_CHUNK,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic [CNT_W-1:0] out_count,
  output logic             busy
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int K_W    = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [K_W-1:0] LAST_K = K_W'(NCHUNK - 1);

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] s_reg, s_next;
  logic [WIDTH-1:0] c_reg, c_next;
  logic             carry_reg, carry_next;
  logic [K_W-1:0]   k_reg, k_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;

  logic [WIDTH-1:0] csa_sum;
  logic [WIDTH-1:0] csa_carry;
  logic [CHUNK-1:0] s_chunk [NCHUNK];
  logic [CHUNK-1:0] c_chunk [NCHUNK];
  logic [CHUNK:0]   chunk_sum;

  csa_3to2_row #(
    .WIDTH(WIDTH)
  ) u_csa (
    .a    (s_reg),
    .b    (c_reg),
    .c    (in_data),
    .sum  (csa_sum),
    .carry(csa_carry)
  );

  for (genvar gi = 0; gi < NCHUNK; gi++) begin : g_chunk_sel
    assign s_chunk[gi] = s_reg[gi*CHUNK +: CHUNK];
    assign c_chunk[gi] = c_reg[gi*CHUNK +: CHUNK];
  end

  // One CHUNK-wide ripple add per RESOLVE cycle; bit CHUNK feeds the next chunk.
  assign chunk_sum = {1'b0, s_chunk[k_reg]} + {1'b0, c_chunk[k_reg]}
                   + {{CHUNK{1'b0}}, carry_reg};

  // Each result chunk is only written during its own RESOLVE slot, so it holds
  // steady through DONE without further gating.
  for (genvar gi = 0; gi < NCHUNK; gi++) begin : g_result
    localparam logic [K_W-1:0] MY_K = K_W'(gi);
    logic [CHUNK-1:0] res_chunk_reg;

    always_ff @(posedge clk) begin
      if (reset) begin
        res_chunk_reg <= '0;
      end else if (state_reg == RESOLVE && k_reg == MY_K) begin
        res_chunk_reg <= chunk_sum[CHUNK-1:0];
      end
    end

    assign out_sum[gi*CHUNK +: CHUNK] = res_chunk_reg;
  end

  assign out_count = cnt_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= IDLE;
      s_reg     <= '0;
      c_reg     <= '0;
      carry_reg <= 1'b0;
      k_reg     <= '0;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      s_reg     <= s_next;
      c_reg     <= c_next;
      carry_reg <= carry_next;
      k_reg     <= k_next;
      cnt_reg   <= cnt_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    s_next     = s_reg;
    c_next     = c_reg;
    carry_next = carry_reg;
    k_next     = k_reg;
    cnt_next   = cnt_reg;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    busy       = (state_reg != IDLE);

    case (state_reg)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          s_next     = in_data;
          c_next     = '0;
          carry_next = 1'b0;
          k_next     = '0;
          cnt_next   = {{(CNT_W-1){1'b0}}, 1'b1};
          state_next = in_last ? RESOLVE : ACCUM;
        end
      end

      ACCUM: begin
        in_ready = 1'b1;
        if (in_valid) begin
          s_next   = csa_sum;
          c_next   = csa_carry;
          cnt_next = CNT_W'(sat_inc(32'(cnt_reg), CNT_W));
          if (in_last) begin
            carry_next = 1'b0;
            k_next     = '0;
            state_next = RESOLVE;
          end
        end
      end

      RESOLVE: begin
        carry_next = chunk_sum[CHUNK];
        k_next     = k_reg + 1'b1;
        if (k_reg == LAST_K) begin
          // Carry out of the top chunk is the mod-2^WIDTH overflow; discard it.
          carry_next = 1'b0;
          k_next     = '0;
          state_next = DONE;
        end
      end

      DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_next = IDLE;
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_csa_accum_sequencer.sv
// Self-checking bench: directed vector table, hand-written corner sequences and
// a randomized regression against a modulo-2^64 reference sum.
module tb_csa_accum_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] in_data;
  logic        in_last;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_sum;
  logic [15:0] out_count;
  logic        busy;

  logic        sat_in_ready;
  logic        sat_out_valid;
  logic [63:0] sat_sum;
  logic [2:0]  sat_count;
  logic        sat_busy;

  int pass_cnt  = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  csa_accum_sequencer dut (
    .clk      (clk),
    .reset    (reset),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .in_last  (in_last),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_sum  (out_sum),
    .out_count(out_count),
    .busy     (busy)
  );

  // Narrow-counter copy sharing the same stimulus, used for the saturation case.
  csa_accum_sequencer #(.CNT_W(3)) dut_sat (
    .clk      (clk),
    .reset    (reset),
    .in_valid (in_valid),
    .in_ready (sat_in_ready),
    .in_data  (in_data),
    .in_last  (in_last),
    .out_valid(sat_out_valid),
    .out_ready(out_ready),
    .out_sum  (sat_sum),
    .out_count(sat_count),
    .busy     (sat_busy)
  );

  typedef struct {
    string            name;
    logic [3:0][63:0] ops;
    int               n;
    int               gap;
    int               hold;
    logic [63:0]      exp_sum;
    int               exp_cnt;
  } vec_t;

  vec_t vecs[7];

  function automatic vec_t mk(input string nm, input logic [63:0] a, input logic [63:0] b,
                              input logic [63:0] c, input logic [63:0] d, input int n,
                              input int gap, input int hold, input logic [63:0] es,
                              input int ec);
    vec_t v;
    v.name    = nm;
    v.ops[0]  = a;
    v.ops[1]  = b;
    v.ops[2]  = c;
    v.ops[3]  = d;
    v.n       = n;
    v.gap     = gap;
    v.hold    = hold;
    v.exp_sum = es;
    v.exp_cnt = ec;
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    total_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%h required 0x%h", name, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one beat and hold it until the accepting edge has passed.
  task automatic send(input logic [63:0] d, input logic last, input bit expect_ready);
    int w;
    w        = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    if (expect_ready) check("in_ready_b2b", {63'd0, in_ready}, 64'd1);
    while (!in_ready && w < 50) begin
      tick();
      w++;
    end
    if (!in_ready) begin
      total_cnt++;
      $display("FAIL in_ready_timeout: got in_ready=0 required 1 within 50 cycles");
    end
    tick();
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_data  = {$urandom(), $urandom()};
  endtask

  // Wait for out_valid, stall for 'hold' cycles checking stability, then handshake.
  // lat counts edges after the accepting edge until out_valid is seen.
  task automatic get_result(input int hold, output logic [63:0] sum,
                            output logic [15:0] cnt, output int lat);
    lat = 0;
    while (!out_valid && lat < 40) begin
      tick();
      lat++;
    end
    if (!out_valid) begin
      total_cnt++;
      $display("FAIL out_valid_timeout: got out_valid=0 required 1 within 40 cycles");
    end
    sum       = out_sum;
    cnt       = out_count;
    out_ready = 1'b0;
    for (int h = 0; h < hold; h++) begin
      tick();
      check("hold_valid", {63'd0, out_valid}, 64'd1);
      check("hold_sum", out_sum, sum);
      check("hold_count", {48'd0, out_count}, {48'd0, cnt});
      check("hold_in_ready", {63'd0, in_ready}, 64'd0);
    end
    out_ready = 1'b1;
    tick();
    check("valid_pulse_end", {63'd0, out_valid}, 64'd0);
    out_ready = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [63:0] s;
    logic [15:0] c;
    int          lat;
    logic [63:0] exp_sum;
    logic [63:0] d;
    int          n;

    reset     = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    in_last   = 1'b0;
    out_ready = 1'b0;

    vecs[0] = mk("single", 64'h0123_4567_89AB_CDEF, 0, 0, 0, 1, 0, 0,
                 64'h0123_4567_89AB_CDEF, 1);
    vecs[1] = mk("wrap3", 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 64'h1, 0, 3, 0, 0, 64'h1, 3);
    vecs[2] = mk("chunk_carry", 64'h0000_0000_0000_FFFF, 64'h1, 0, 0, 2, 0, 0,
                 64'h0000_0000_0001_0000, 2);
    vecs[3] = mk("gaps_bp", 64'd10, 64'd20, 64'd30, 64'd40, 4, 2, 3, 64'd100, 4);
    vecs[4] = mk("msb_drop", 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 0, 0,
                 2, 0, 1, 64'h0, 2);
    vecs[5] = mk("neg_ones4", 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF,
                 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 4, 1, 0,
                 64'hFFFF_FFFF_FFFF_FFFC, 4);
    vecs[6] = mk("alt_bits", 64'h5555_5555_5555_5555, 64'hAAAA_AAAA_AAAA_AAAA, 64'h1, 0,
                 3, 0, 2, 64'h0, 3);

    tick();
    tick();
    check("rst_in_ready", {63'd0, in_ready}, 64'd1);
    check("rst_out_valid", {63'd0, out_valid}, 64'd0);
    check("rst_out_sum", out_sum, 64'd0);
    check("rst_out_count", {48'd0, out_count}, 64'd0);
    check("rst_busy", {63'd0, busy}, 64'd0);
    reset = 1'b0;
    tick();

    // Directed vector table
    for (int i = 0; i < 7; i++) begin
      for (int j = 0; j < vecs[i].n; j++) begin
        send(vecs[i].ops[j], (j == vecs[i].n - 1), (vecs[i].gap == 0));
        if (j < vecs[i].n - 1) begin
          // in_last and out_ready during the gap must be ignored
          in_last   = 1'b1;
          out_ready = 1'b1;
          for (int g = 0; g < vecs[i].gap; g++) begin
            tick();
            check("gap_busy", {63'd0, busy}, 64'd1);
          end
          in_last   = 1'b0;
          out_ready = 1'b0;
        end
      end
      get_result(vecs[i].hold, s, c, lat);
      check({vecs[i].name, "_sum"}, s, vecs[i].exp_sum);
      check({vecs[i].name, "_count"}, {48'd0, c}, 64'(vecs[i].exp_cnt));
      check({vecs[i].name, "_latency"}, 64'(lat + 1), 64'd5);
      $display("vec %s: sum=0x%h count=%0d latency=%0d", vecs[i].name, s, c, lat + 1);
    end

    // Reset in the middle of ACCUM
    send(64'd11, 1'b0, 1'b0);
    send(64'd22, 1'b0, 1'b0);
    check("mid_accum_busy", {63'd0, busy}, 64'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("rst_accum_busy", {63'd0, busy}, 64'd0);
    check("rst_accum_in_ready", {63'd0, in_ready}, 64'd1);
    check("rst_accum_count", {48'd0, out_count}, 64'd0);
    check("rst_accum_sum", out_sum, 64'd0);
    send(64'd7, 1'b1, 1'b0);
    get_result(0, s, c, lat);
    check("after_rst_sum", s, 64'd7);
    check("after_rst_count", {48'd0, c}, 64'd1);
    $display("reset mid-accum: sum=0x%h count=%0d", s, c);

    // Reset while a result is pending in DONE
    send(64'd5, 1'b1, 1'b0);
    n = 0;
    while (!out_valid && n < 40) begin
      tick();
      n++;
    end
    check("done_pending_valid", {63'd0, out_valid}, 64'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("rst_done_valid", {63'd0, out_valid}, 64'd0);
    tick();
    check("rst_done_valid_stays", {63'd0, out_valid}, 64'd0);
    $display("reset in done: out_valid=%0d", out_valid);

    // Counter saturation on the 3-bit copy; sum must stay exact
    for (int i = 1; i <= 10; i++) send(64'(i), (i == 10), 1'b0);
    n = 0;
    while (!out_valid && n < 40) begin
      tick();
      n++;
    end
    check("sat_valid", {63'd0, sat_out_valid}, 64'd1);
    check("sat_count", {61'd0, sat_count}, 64'd7);
    check("sat_sum", sat_sum, 64'd55);
    check("sat_busy", {63'd0, sat_busy}, 64'd1);
    check("sat_in_ready", {63'd0, sat_in_ready}, 64'd0);
    get_result(0, s, c, lat);
    check("nosat_count", {48'd0, c}, 64'd10);
    check("nosat_sum", s, 64'd55);
    $display("saturation: wide count=%0d narrow count=%0d sum=%0d", c, sat_count, s);

    // Random regression with valid and ready stalls
    for (int p = 0; p < 150; p++) begin
      n       = $urandom_range(1, 300);
      exp_sum = '0;
      for (int j = 0; j < n; j++) begin
        d       = {$urandom(), $urandom()};
        exp_sum = exp_sum + d;
        while ($urandom_range(0, 3) == 0) tick();
        send(d, (j == n - 1), 1'b0);
      end
      get_result($urandom_range(0, 3), s, c, lat);
      check("rand_sum", s, exp_sum);
      check("rand_count", {48'd0, c}, 64'(n));
      $display("rand pkt %0d: ops=%0d sum=0x%h count=%0d", p, n, s, c);
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
